// File: rtl/game_sequencer_pkg.sv
// Shared types and constants for the tic-tac-toe turn/rules sequencer.
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      OVER  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      X_WIN = 2'b01,
      O_WIN = 2'b10,
      DRAW  = 2'b11
   } winner_t;

   localparam int C_NUM_LINES = 8;

   // Row-major cell numbering: bit 0 top-left, bit 8 bottom-right.
   localparam logic [C_NUM_LINES-1:0][8:0] C_LINES = {
      9'h054, 9'h111,
      9'h124, 9'h092, 9'h049,
      9'h1C0, 9'h038, 9'h007
   };

   function automatic logic is_onehot(input logic [8:0] v);
      return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_sequencer_if.sv
// Cursor/button inputs and board/result outputs of the sequencer.
`default_nettype none

interface game_sequencer_if;
   logic [8:0] cursor;
   logic       write;
   logic       newGame;
   logic [8:0] boardX;
   logic [8:0] boardO;
   logic       turn;
   logic [1:0] winner;
   logic [8:0] winLine;
   logic       gameOver;
   logic       illegal;

   modport master (
      output cursor, write, newGame,
      input  boardX, boardO, turn, winner, winLine, gameOver, illegal
   );

   modport slave (
      input  cursor, write, newGame,
      output boardX, boardO, turn, winner, winLine, gameOver, illegal
   );
endinterface

`default_nettype wire

// File: rtl/game_sequencer_line_check.sv
// Combinational win-line evaluation of one player's 9-cell board.
`default_nettype none

module line_check
   import game_pkg::*;
(
   input  wire logic [8:0] i_board,
   output logic            o_won,
   output logic [8:0]      o_winLine
);

   logic [C_NUM_LINES-1:0]      w_full;
   logic [C_NUM_LINES-1:0][8:0] w_hitMask;

   generate
      for (genvar k = 0; k < C_NUM_LINES; k++) begin : g_lines
         assign w_full[k]    = ((i_board & C_LINES[k]) == C_LINES[k]);
         assign w_hitMask[k] = w_full[k] ? C_LINES[k] : 9'd0;
      end
   endgenerate

   // Several lines can close on one move; report their union.
   always_comb begin
      o_winLine = 9'd0;
      for (int k = 0; k < C_NUM_LINES; k++) begin
         o_winLine = o_winLine | w_hitMask[k];
      end
   end

   assign o_won = |w_full;

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// Tic-tac-toe turn/rules sequencer: owns both boards, validates moves, reports win/draw.
`default_nettype none

module game_sequencer
   import game_pkg::*;
#(
   parameter bit ALT_START = 1'b0
) (
   input wire logic   clk,
   input wire logic   resetN,
   game_sequencer_if.slave bus
);

   state_t     r_state;
   state_t     w_stateNext;
   logic [8:0] r_boardX;
   logic [8:0] r_boardO;
   logic       r_turn;
   logic       r_startPlayer;
   logic [3:0] r_moveCount;
   winner_t    r_winner;
   logic [8:0] r_winLine;
   logic       r_illegal;
   logic       r_writeQ;

   logic       w_writeRise;
   logic       w_legal;
   logic       w_won;
   logic [8:0] w_lineMask;
   logic       w_boardFull;
   logic       w_place;
   logic       w_reject;
   logic       w_setWin;
   logic       w_setDraw;
   logic       w_toggle;

   assign w_writeRise = bus.write & ~r_writeQ;
   assign w_legal     = is_onehot(bus.cursor) &&
                        (((r_boardX | r_boardO) & bus.cursor) == 9'd0);
   assign w_boardFull = (r_moveCount == 4'd9);

   // Turn has not toggled yet in CHECK, so this is the mover's board.
   line_check u_line_check (
      .i_board   (r_turn ? r_boardO : r_boardX),
      .o_won     (w_won),
      .o_winLine (w_lineMask)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= PLAY;
      else         r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      if (bus.newGame) begin
         w_stateNext = PLAY;
      end else begin
         case (r_state)
            PLAY:    if (w_writeRise && w_legal) w_stateNext = CHECK;
            CHECK:   w_stateNext = (w_won || w_boardFull) ? OVER : PLAY;
            OVER:    w_stateNext = OVER;
            default: w_stateNext = PLAY;
         endcase
      end
   end

   always_comb begin
      w_place   = 1'b0;
      w_reject  = 1'b0;
      w_setWin  = 1'b0;
      w_setDraw = 1'b0;
      w_toggle  = 1'b0;
      if (!bus.newGame) begin
         case (r_state)
            PLAY: begin
               w_place  = w_writeRise &  w_legal;
               w_reject = w_writeRise & ~w_legal;
            end
            CHECK: begin
               w_setWin  = w_won;
               w_setDraw = ~w_won &  w_boardFull;
               w_toggle  = ~w_won & ~w_boardFull;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_boardX      <= 9'd0;
         r_boardO      <= 9'd0;
         r_turn        <= 1'b0;
         r_startPlayer <= 1'b0;
         r_moveCount   <= 4'd0;
         r_winner      <= NONE;
         r_winLine     <= 9'd0;
         r_illegal     <= 1'b0;
         r_writeQ      <= 1'b1;
      end else begin
         r_writeQ  <= bus.write;
         r_illegal <= w_reject;
         if (bus.newGame) begin
            r_boardX      <= 9'd0;
            r_boardO      <= 9'd0;
            r_moveCount   <= 4'd0;
            r_winner      <= NONE;
            r_winLine     <= 9'd0;
            r_startPlayer <= r_startPlayer ^ ALT_START;
            r_turn        <= r_startPlayer ^ ALT_START;
         end else begin
            if (w_place) begin
               if (r_turn) r_boardO <= r_boardO | bus.cursor;
               else        r_boardX <= r_boardX | bus.cursor;
               r_moveCount <= r_moveCount + 4'd1;
            end
            if (w_setWin) begin
               r_winner  <= r_turn ? O_WIN : X_WIN;
               r_winLine <= w_lineMask;
            end
            if (w_setDraw) begin
               r_winner  <= DRAW;
               r_winLine <= 9'd0;
            end
            if (w_toggle) r_turn <= ~r_turn;
         end
      end
   end

   assign bus.boardX   = r_boardX;
   assign bus.boardO   = r_boardO;
   assign bus.turn     = r_turn;
   assign bus.winner   = r_winner;
   assign bus.winLine  = r_winLine;
   assign bus.gameOver = (r_state == OVER);
   assign bus.illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// Randomized + directed bench for game_sequencer against a cell-triple reference model.
`default_nettype none

module tb_game_sequencer;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   game_sequencer_if bus0();
   game_sequencer_if bus1();

   game_sequencer #(.ALT_START(1'b0)) dut0 (.clk(clk), .resetN(resetN), .bus(bus0.slave));
   game_sequencer #(.ALT_START(1'b1)) dut1 (.clk(clk), .resetN(resetN), .bus(bus1.slave));

   int total = 0;
   int bad   = 0;

   // Model state, index 0 = fixed X start, 1 = alternating start.
   logic [8:0] mX [2];
   logic [8:0] mO [2];
   logic       mTurn [2];
   logic       mStart [2];
   int         mCount [2];
   int         mPhase [2];
   logic [1:0] mWinner [2];
   logic [8:0] mWinLine [2];
   logic       mIll [2];
   logic       mWq [2];

   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mX[k] = 0; mO[k] = 0; mTurn[k] = 0; mStart[k] = 0; mCount[k] = 0;
         mPhase[k] = 0; mWinner[k] = 0; mWinLine[k] = 0; mIll[k] = 0; mWq[k] = 1;
      end
   endtask

   task automatic model_clk(input int k, input logic [8:0] cur, input logic wr, input logic ng);
      logic       rise;
      logic [8:0] b;
      logic [8:0] mask;
      logic       full;
      rise   = wr && !mWq[k];
      mWq[k] = wr;
      if (ng) begin
         mX[k] = 0; mO[k] = 0; mCount[k] = 0; mWinner[k] = 0; mWinLine[k] = 0; mIll[k] = 0;
         if (k == 1) mStart[k] = ~mStart[k];
         mTurn[k]  = mStart[k];
         mPhase[k] = 0;
         return;
      end
      mIll[k] = 0;
      if (mPhase[k] == 0) begin
         if (rise) begin
            if ($countones(cur) == 1 && ((mX[k] | mO[k]) & cur) == 0) begin
               if (mTurn[k]) mO[k] = mO[k] | cur;
               else          mX[k] = mX[k] | cur;
               mCount[k]++;
               mPhase[k] = 1;
            end else begin
               mIll[k] = 1;
            end
         end
      end else if (mPhase[k] == 1) begin
         b    = mTurn[k] ? mO[k] : mX[k];
         mask = 0;
         full = 0;
         for (int l = 0; l < 8; l++) begin
            if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) begin
               full = 1;
               for (int j = 0; j < 3; j++) mask[lines[l][j]] = 1'b1;
            end
         end
         if (full) begin
            mWinner[k]  = mTurn[k] ? 2'b10 : 2'b01;
            mWinLine[k] = mask;
            mPhase[k]   = 2;
         end else if (mCount[k] == 9) begin
            mWinner[k]  = 2'b11;
            mWinLine[k] = 0;
            mPhase[k]   = 2;
         end else begin
            mTurn[k]  = ~mTurn[k];
            mPhase[k] = 0;
         end
      end
   endtask

   task automatic compare(input int k, input logic [8:0] bx, input logic [8:0] bo, input logic t,
                          input logic [1:0] w, input logic [8:0] wl, input logic go, input logic il);
      check($sformatf("d%0d boardX", k),   32'(bx), 32'(mX[k]));
      check($sformatf("d%0d boardO", k),   32'(bo), 32'(mO[k]));
      check($sformatf("d%0d turn", k),     32'(t),  32'(mTurn[k]));
      check($sformatf("d%0d winner", k),   32'(w),  32'(mWinner[k]));
      check($sformatf("d%0d winLine", k),  32'(wl), 32'(mWinLine[k]));
      check($sformatf("d%0d gameOver", k), 32'(go), 32'(mPhase[k] == 2));
      check($sformatf("d%0d illegal", k),  32'(il), 32'(mIll[k]));
   endtask

   task automatic compare_all();
      compare(0, bus0.boardX, bus0.boardO, bus0.turn, bus0.winner, bus0.winLine, bus0.gameOver, bus0.illegal);
      compare(1, bus1.boardX, bus1.boardO, bus1.turn, bus1.winner, bus1.winLine, bus1.gameOver, bus1.illegal);
   endtask

   task automatic step(input logic [8:0] cur, input logic wr, input logic ng);
      bus0.cursor = cur; bus0.write = wr; bus0.newGame = ng;
      bus1.cursor = cur; bus1.write = wr; bus1.newGame = ng;
      @(posedge clk);
      model_clk(0, cur, wr, ng);
      model_clk(1, cur, wr, ng);
      #1;
      compare_all();
   endtask

   task automatic move(input logic [8:0] cur);
      step(cur, 1'b1, 1'b0);
      step(cur, 1'b0, 1'b0);
   endtask

   initial begin
      logic [8:0] seq [9];
      logic [8:0] cur;
      logic       wr;
      logic       ng;

      resetN = 1'b0;
      bus0.cursor = 9'h001; bus0.write = 1'b1; bus0.newGame = 1'b0;
      bus1.cursor = 9'h001; bus1.write = 1'b1; bus1.newGame = 1'b0;
      model_reset();
      #23;
      compare_all();
      @(negedge clk);
      resetN = 1'b1;
      step(9'h001, 1'b1, 1'b0);
      step(9'h001, 1'b1, 1'b0);
      check("held write boardX", 32'(bus0.boardX), 32'h0);
      check("held write turn",   32'(bus0.turn),   32'h0);

      step(9'h000, 1'b0, 1'b1);
      check("alt start first newGame turn", 32'(bus1.turn), 32'h1);

      seq = '{9'h001, 9'h008, 9'h002, 9'h010, 9'h004, 9'h0, 9'h0, 9'h0, 9'h0};
      for (int i = 0; i < 5; i++) move(seq[i]);
      check("row win winner",   32'(bus0.winner),   32'h1);
      check("row win winLine",  32'(bus0.winLine),  32'h007);
      check("row win gameOver", 32'(bus0.gameOver), 32'h1);

      step(9'h000, 1'b0, 1'b1);
      check("alt start second newGame turn", 32'(bus1.turn), 32'h0);
      move(9'h001);
      step(9'h002, 1'b1, 1'b1);
      check("newGame vs rise boardX", 32'(bus0.boardX), 32'h0);
      check("newGame vs rise boardO", 32'(bus0.boardO), 32'h0);
      step(9'h002, 1'b0, 1'b0);

      move(9'h001);
      step(9'h001, 1'b1, 1'b0);
      check("occupied illegal", 32'(bus0.illegal), 32'h1);
      check("occupied boardO",  32'(bus0.boardO),  32'h0);
      step(9'h001, 1'b0, 1'b0);
      check("occupied illegal drop", 32'(bus0.illegal), 32'h0);
      check("occupied turn",         32'(bus0.turn),    32'h1);
      step(9'h003, 1'b1, 1'b0);
      check("not onehot illegal", 32'(bus0.illegal), 32'h1);
      step(9'h000, 1'b0, 1'b0);

      step(9'h000, 1'b0, 1'b1);
      seq = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h020, 9'h010, 9'h040, 9'h100, 9'h080};
      for (int i = 0; i < 9; i++) move(seq[i]);
      check("draw winner",  32'(bus0.winner),  32'h3);
      check("draw winLine", 32'(bus0.winLine), 32'h0);

      step(9'h000, 1'b0, 1'b1);
      seq = '{9'h002, 9'h008, 9'h004, 9'h020, 9'h010, 9'h040, 9'h100, 9'h080, 9'h001};
      for (int i = 0; i < 9; i++) move(seq[i]);
      check("double win winner",  32'(bus0.winner),  32'h1);
      check("double win winLine", 32'(bus0.winLine), 32'h117);

      for (int n = 0; n < 1500; n++) begin
         ng = ($urandom_range(0, 39) == 0);
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 8) cur = 9'h001 << $urandom_range(0, 8);
         else                         cur = 9'($urandom);
         step(cur, wr, ng);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
# game_sequencer

Turn and rules sequencer for the tic-tac-toe board. It sits between the cursor controller (one-hot 9-bit cursor plus raw write button) and the display/VGA path. It owns the X and O board registers, alternates players, and rejects illegal moves. After every accepted move it evaluates all eight win lines and reports win or draw.

## Interface
Parameters:
- ALT_START, default 0: 0 = X opens every game; 1 = opening player alternates on each newGame.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- resetN  input  1  asynchronous, active-low reset.
- cursor  input  9  one-hot cell select; bit 0 = top-left, bit 8 = bottom-right, row-major.
- write  input  1  raw center-button level, synchronous to clk.
- newGame  input  1  level; clears the board on any cycle it is sampled high.
- boardX  output  9  cells held by X.
- boardO  output  9  cells held by O.
- turn  output  1  player to move: 0 = X, 1 = O.
- winner  output  2  00 = none, 01 = X, 10 = O, 11 = draw.
- winLine  output  9  mask of cells on the completed line(s); 0 otherwise.
- gameOver  output  1  high in state OVER.
- illegal  output  1  one-cycle pulse on a rejected move.

## Operation
- Edge detect:
  - writeQ is a registered copy of write.
  - writeRise = write & ~writeQ.
  - writeQ resets to 1, so a button held through reset never places a mark.
- Registers: boardX, boardO, turn, startPlayer, moveCount[3:0], state, winner, winLine, illegal.
- Invariant: boardX & boardO == 0 at all times.
- State PLAY, on writeRise, the move is legal if all of the following hold:
  - cursor is exactly one-hot;
  - (boardX | boardO) & cursor == 0.
- PLAY, legal move:
  - OR cursor into the board of the current turn;
  - moveCount + 1;
  - go to CHECK.
- PLAY, illegal move:
  - illegal = 1 for one cycle;
  - board unchanged; stay in PLAY.
- CHECK evaluates the mover's board (turn not yet toggled) against the 8 line masks.
  - Any line full: winner = turn ? 10 : 01; winLine = OR of all full lines; go to OVER.
  - Else if moveCount == 9: winner = 11; winLine = 0; go to OVER.
  - Else: toggle turn; go to PLAY.
- OVER:
  - write is ignored;
  - outputs hold until newGame.
- newGame, in any state:
  - takes priority over a same-cycle writeRise;
  - clears boards, moveCount, winner, winLine and illegal;
  - when ALT_START = 1, startPlayer toggles;
  - turn loads the new startPlayer;
  - state goes to PLAY.
- A writeRise during CHECK or OVER is dropped. It is not queued.
- A win on the 9th move reports the winner, not a draw.

## Timing
- Reset values:
  - boardX = boardO = 0;
  - turn = 0, startPlayer = 0;
  - winner = 00, winLine = 0;
  - gameOver = 0, illegal = 0;
  - moveCount = 0;
  - state PLAY, writeQ = 1.
- Latency for a writeRise sampled at edge n:
  - board bit visible after edge n;
  - result visible after edge n+1, as either winner/gameOver set or turn toggled;
  - total: 2 cycles from the press edge to the next move being accepted.
- illegal asserts after edge n and deasserts after edge n+1.
- newGame sampled at edge n: cleared outputs visible after edge n.
- resetN low: all registers take reset values immediately, mid-CHECK included.

## Structure
- game_pkg holds:
  - state encoding (PLAY, CHECK, OVER);
  - winner codes (NONE, X_WIN, O_WIN, DRAW);
  - the 8 nine-bit line mask constants (rows 0x007/0x038/0x1C0, columns 0x049/0x092/0x124, diagonals 0x111/0x054).
- One sub-module: line_check. It is combinational and takes the 9-bit board. Its outputs are:
  - won;
  - 9-bit winLine mask.
- The FSM, registers and edge detect stay in game_sequencer.

## Test plan
- Reset with write held high, then release resetN: no mark placed; boardX = 0, turn = 0.
- X plays cursor 0x001, O 0x008, X 0x002, O 0x010, X 0x004: winner = 01, winLine = 0x007, gameOver = 1 two cycles after the last rise.
- O presses a cell X already holds (0x001): illegal pulses for exactly 1 cycle; boardO unchanged; turn stays 1.
- Fill the board with no line (X: 0x001, 0x004, 0x020, 0x040, 0x080; O: 0x002, 0x008, 0x010, 0x100, in alternation): after the 9th move winner = 11, winLine = 0.
- Two-line win: the 9th move completes row 0x007 and diagonal 0x111 at once, giving winLine = 0x117. A separate check: cursor = 0x003 (not one-hot) is rejected with an illegal pulse.
- newGame asserted in the same cycle as a writeRise in PLAY: board cleared, no mark placed. With ALT_START = 1, turn becomes 1 after the first newGame and 0 after the second.
